mmio_store_unit: RTL and testbench

MMIO_STORE_UNIT -- requirements
Module: mmio_store_unit

---
 rtl/mmio_store_unit_pkg.sv | 29 ++
 rtl/mmio_store_unit_store_mask_gen.sv | 47 ++++
 rtl/mmio_store_unit.sv | 155 +++++++++++++++
 tb/tb_mmio_store_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_store_unit_pkg.sv
// Shared constants for the MMIO store unit: store codes, region nibbles,
// MMIO register addresses and the TX buffer state type.
package mmio_store_unit_pkg;

    // funct3 encodings of the three RV32 store instructions
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Top address nibble of each memory region
    localparam logic [3:0] REGION_DMEM_LO = 4'b0001;
    localparam logic [3:0] REGION_DMEM_HI = 4'b0011;
    localparam logic [3:0] REGION_BIOS    = 4'b0100;
    // IMEM is any address with top three bits 001
    localparam logic [2:0] REGION_IMEM    = 3'b001;

    // Memory-mapped register addresses
    localparam logic [31:0] ADDR_UART_TX   = 32'h8000_0008;
    localparam logic [31:0] ADDR_CNT_RESET = 32'h8000_0018;
    localparam logic [31:0] ADDR_CONV_GO   = 32'h8001_0000;
    localparam logic [31:0] ADDR_CONV_CFG  = 32'h8001_0004;

    // One-entry UART transmit buffer
    typedef enum logic {
        TX_EMPTY = 1'b0,
        TX_FULL  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/mmio_store_unit_store_mask_gen.sv
// Combinational byte-enable and lane-replication logic for RV32 stores.
module store_mask_gen
    import mmio_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic        store_ok
);

    // Decode store width into lane enables and replicated write data
    always_comb begin
        byte_en  = 4'b0000;
        wdata    = data;
        misalign = 1'b0;
        store_ok = 1'b0;
        case (funct3)
            F3_SB: begin
                byte_en  = 4'b0001 << addr_lo;
                wdata    = {4{data[7:0]}};
                store_ok = 1'b1;
            end
            F3_SH: begin
                wdata = {2{data[15:0]}};
                if (addr_lo[0]) begin
                    misalign = 1'b1;
                end else begin
                    byte_en  = 4'b0011 << addr_lo;
                    store_ok = 1'b1;
                end
            end
            F3_SW: begin
                if (addr_lo != 2'b00) begin
                    misalign = 1'b1;
                end else begin
                    byte_en  = 4'b1111;
                    store_ok = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mmio_store_unit.sv
// MEM-stage store unit: memory write enables, UART TX buffer, cycle and
// instret counters, and the convolution accelerator start/config registers.
module mmio_store_unit
    import mmio_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid_i,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    input  logic [2:0]  st_funct3_i,
    input  logic        pc30_i,
    input  logic        inst_valid_i,
    input  logic        tx_ready_i,
    output logic [3:0]  dmem_we_o,
    output logic [3:0]  imem_we_o,
    output logic [13:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    output logic        conv_start_o,
    output logic [31:0] conv_cfg_o,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_cnt_o,
    output logic        stall_o,
    output logic        misalign_o
);

    logic [3:0]  byte_en;
    logic        mask_misalign;
    logic        mask_ok;
    logic        store_acc;
    logic        tx_store;
    logic        cnt_clear;
    logic        cfg_store;
    logic        go_store;
    logic        in_dmem;
    logic        in_imem;
    logic        stall;
    logic        tx_load;

    tx_state_t   state_reg;
    tx_state_t   state_next;
    logic [7:0]  tx_data_reg;
    logic [31:0] cycle_cnt_reg;
    logic [31:0] instret_cnt_reg;
    logic [31:0] conv_cfg_reg;
    logic        conv_start_reg;

    store_mask_gen u_mask (
        .funct3   (st_funct3_i),
        .addr_lo  (st_addr_i[1:0]),
        .data     (st_data_i),
        .byte_en  (byte_en),
        .wdata    (mem_wdata_o),
        .misalign (mask_misalign),
        .store_ok (mask_ok)
    );

    // A store has side effects only if it is valid, aligned and a known width
    assign store_acc = st_valid_i && mask_ok;
    assign tx_store  = store_acc && (st_addr_i == ADDR_UART_TX);
    assign cnt_clear = store_acc && (st_addr_i == ADDR_CNT_RESET);
    assign cfg_store = store_acc && (st_addr_i == ADDR_CONV_CFG);
    assign go_store  = store_acc && (st_addr_i == ADDR_CONV_GO);

    // BIOS and unmapped regions match neither decode and are dropped here
    assign in_dmem = (st_addr_i[31:28] == REGION_DMEM_LO) ||
                     (st_addr_i[31:28] == REGION_DMEM_HI);
    assign in_imem = (st_addr_i[31:29] == REGION_IMEM) && pc30_i;

    assign mem_addr_o = st_addr_i[15:2];
    assign dmem_we_o  = (store_acc && in_dmem && !stall) ? byte_en : 4'b0000;
    assign imem_we_o  = (store_acc && in_imem && !stall) ? byte_en : 4'b0000;
    assign misalign_o = st_valid_i && mask_misalign;
    assign stall_o    = stall;

    // TX buffer next state: load when there is room or the held byte drains
    // this cycle; otherwise a TX store stalls the pipeline
    always_comb begin
        state_next = state_reg;
        tx_load    = 1'b0;
        stall      = 1'b0;
        case (state_reg)
            TX_EMPTY: begin
                if (tx_store) begin
                    tx_load    = 1'b1;
                    state_next = TX_FULL;
                end
            end
            TX_FULL: begin
                if (tx_store) begin
                    if (tx_ready_i) begin
                        tx_load = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end else if (tx_ready_i) begin
                    state_next = TX_EMPTY;
                end
            end
            default: state_next = TX_EMPTY;
        endcase
    end

    // TX buffer state and data; reset drops any byte in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= TX_EMPTY;
            tx_data_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            if (tx_load) begin
                tx_data_reg <= st_data_i[7:0];
            end
        end
    end

    // Performance counters; a counter-reset store beats the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_reg   <= 32'h0;
            instret_cnt_reg <= 32'h0;
        end else if (cnt_clear) begin
            cycle_cnt_reg   <= 32'h0;
            instret_cnt_reg <= 32'h0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'h1;
            if (inst_valid_i && !stall) begin
                instret_cnt_reg <= instret_cnt_reg + 32'h1;
            end
        end
    end

    // Accelerator config word and one-cycle start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_cfg_reg   <= 32'h0;
            conv_start_reg <= 1'b0;
        end else begin
            conv_start_reg <= go_store;
            if (cfg_store) begin
                conv_cfg_reg <= st_data_i;
            end
        end
    end

    assign tx_valid_o    = (state_reg == TX_FULL);
    assign tx_data_o     = tx_data_reg;
    assign cycle_cnt_o   = cycle_cnt_reg;
    assign instret_cnt_o = instret_cnt_reg;
    assign conv_cfg_o    = conv_cfg_reg;
    assign conv_start_o  = conv_start_reg;

endmodule

// File: tb/tb_mmio_store_unit.sv
// Directed bench for mmio_store_unit with immediate-assertion checks.
module tb_mmio_store_unit;

    logic        clk;
    logic        rst_n;
    logic        st_valid_i;
    logic [31:0] st_addr_i;
    logic [31:0] st_data_i;
    logic [2:0]  st_funct3_i;
    logic        pc30_i;
    logic        inst_valid_i;
    logic        tx_ready_i;
    logic [3:0]  dmem_we_o;
    logic [3:0]  imem_we_o;
    logic [13:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        conv_start_o;
    logic [31:0] conv_cfg_o;
    logic [31:0] cycle_cnt_o;
    logic [31:0] instret_cnt_o;
    logic        stall_o;
    logic        misalign_o;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_store_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .st_valid_i    (st_valid_i),
        .st_addr_i     (st_addr_i),
        .st_data_i     (st_data_i),
        .st_funct3_i   (st_funct3_i),
        .pc30_i        (pc30_i),
        .inst_valid_i  (inst_valid_i),
        .tx_ready_i    (tx_ready_i),
        .dmem_we_o     (dmem_we_o),
        .imem_we_o     (imem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .tx_valid_o    (tx_valid_o),
        .tx_data_o     (tx_data_o),
        .conv_start_o  (conv_start_o),
        .conv_cfg_o    (conv_cfg_o),
        .cycle_cnt_o   (cycle_cnt_o),
        .instret_cnt_o (instret_cnt_o),
        .stall_o       (stall_o),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        st_valid_i  = 1'b1;
        st_funct3_i = f3;
        st_addr_i   = addr;
        st_data_i   = data;
    endtask

    task automatic idle();
        st_valid_i  = 1'b0;
        st_funct3_i = 3'b000;
        st_addr_i   = 32'h0;
        st_data_i   = 32'h0;
    endtask

    initial begin
        rst_n        = 1'b0;
        pc30_i       = 1'b0;
        inst_valid_i = 1'b0;
        tx_ready_i   = 1'b0;
        idle();

        // Reset state
        #12;
        chk("rst_tx_valid", {31'b0, tx_valid_o}, 32'h0);
        chk("rst_tx_data", {24'b0, tx_data_o}, 32'h0);
        chk("rst_conv_cfg", conv_cfg_o, 32'h0);
        chk("rst_conv_start", {31'b0, conv_start_o}, 32'h0);
        chk("rst_cycle", cycle_cnt_o, 32'h0);
        chk("rst_instret", instret_cnt_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // SB 0xA5 to 0x10000003
        @(negedge clk);
        store(3'b000, 32'h1000_0003, 32'h0000_00A5);
        #1;
        chk("sb_dmem_we", {28'b0, dmem_we_o}, 32'h8);
        chk("sb_wdata", mem_wdata_o, 32'hA5A5_A5A5);
        chk("sb_addr", {18'b0, mem_addr_o}, 32'h0);
        chk("sb_imem_we", {28'b0, imem_we_o}, 32'h0);

        // Misaligned SH
        @(negedge clk);
        store(3'b001, 32'h1000_0001, 32'h0000_1234);
        #1;
        chk("sh_mis_flag", {31'b0, misalign_o}, 32'h1);
        chk("sh_mis_dmem", {28'b0, dmem_we_o}, 32'h0);
        chk("sh_mis_imem", {28'b0, imem_we_o}, 32'h0);

        // Aligned SH to upper half
        @(negedge clk);
        store(3'b001, 32'h1000_0006, 32'hFFFF_1234);
        #1;
        chk("sh_dmem_we", {28'b0, dmem_we_o}, 32'hC);
        chk("sh_wdata", mem_wdata_o, 32'h1234_1234);
        chk("sh_addr", {18'b0, mem_addr_o}, 32'h1);
        chk("sh_misalign", {31'b0, misalign_o}, 32'h0);

        // SW to IMEM without and with PC[30]
        @(negedge clk);
        store(3'b010, 32'h2000_0004, 32'hDEAD_BEEF);
        #1;
        chk("sw_imem_nopc", {28'b0, imem_we_o}, 32'h0);
        pc30_i = 1'b1;
        #1;
        chk("sw_imem_pc", {28'b0, imem_we_o}, 32'hF);
        chk("sw_imem_dmem", {28'b0, dmem_we_o}, 32'h0);
        chk("sw_wdata", mem_wdata_o, 32'hDEAD_BEEF);

        // SW to 0x3 region hits both memories; BIOS region hits neither
        @(negedge clk);
        store(3'b010, 32'h3000_0010, 32'h1111_2222);
        #1;
        chk("sw3_dmem", {28'b0, dmem_we_o}, 32'hF);
        chk("sw3_imem", {28'b0, imem_we_o}, 32'hF);
        store(3'b010, 32'h4000_0000, 32'h1111_2222);
        #1;
        chk("bios_dmem", {28'b0, dmem_we_o}, 32'h0);
        chk("bios_imem", {28'b0, imem_we_o}, 32'h0);
        store(3'b011, 32'h1000_0000, 32'h1111_2222);
        #1;
        chk("bad_f3_dmem", {28'b0, dmem_we_o}, 32'h0);
        st_valid_i = 1'b0;
        st_funct3_i = 3'b010;
        #1;
        chk("novalid_dmem", {28'b0, dmem_we_o}, 32'h0);
        pc30_i = 1'b0;

        // Invalid TX store leaves buffer empty
        @(negedge clk);
        store(3'b000, 32'h8000_0008, 32'h0000_0077);
        st_valid_i = 1'b0;
        @(negedge clk);
        chk("novalid_tx", {31'b0, tx_valid_o}, 32'h0);

        // Counter clear with simultaneous retire
        idle();
        inst_valid_i = 1'b1;
        store(3'b010, 32'h8000_0018, 32'h0);
        @(negedge clk);
        idle();
        #1;
        chk("clr_cycle", cycle_cnt_o, 32'h0);
        chk("clr_instret", instret_cnt_o, 32'h0);

        // TX back-to-back with stall
        @(negedge clk);
        store(3'b000, 32'h8000_0008, 32'h0000_0041);
        #1;
        chk("tx1_stall", {31'b0, stall_o}, 32'h0);
        @(negedge clk);
        store(3'b000, 32'h8000_0008, 32'h0000_0042);
        #1;
        chk("tx2_valid", {31'b0, tx_valid_o}, 32'h1);
        chk("tx2_data", {24'b0, tx_data_o}, 32'h41);
        chk("tx2_stall", {31'b0, stall_o}, 32'h1);
        chk("tx2_cycle", cycle_cnt_o, 32'h2);
        chk("tx2_instret", instret_cnt_o, 32'h2);
        @(negedge clk);
        #1;
        chk("hold_data", {24'b0, tx_data_o}, 32'h41);
        chk("hold_stall", {31'b0, stall_o}, 32'h1);
        chk("hold_cycle", cycle_cnt_o, 32'h3);
        chk("hold_instret", instret_cnt_o, 32'h2);
        tx_ready_i = 1'b1;
        #1;
        chk("ready_stall", {31'b0, stall_o}, 32'h0);
        @(negedge clk);
        idle();
        inst_valid_i = 1'b0;
        #1;
        chk("reload_valid", {31'b0, tx_valid_o}, 32'h1);
        chk("reload_data", {24'b0, tx_data_o}, 32'h42);
        chk("reload_instret", instret_cnt_o, 32'h3);
        @(negedge clk);
        #1;
        chk("drain_valid", {31'b0, tx_valid_o}, 32'h0);
        chk("drain_cycle", cycle_cnt_o, 32'h5);
        chk("drain_instret", instret_cnt_o, 32'h3);

        // Cycle counter wrap
        @(negedge clk);
        force dut.cycle_cnt_reg = 32'hFFFF_FFFF;
        #1;
        chk("preset_cycle", cycle_cnt_o, 32'hFFFF_FFFF);
        release dut.cycle_cnt_reg;
        @(negedge clk);
        chk("wrap_cycle", cycle_cnt_o, 32'h0);

        // Accelerator config and start pulse
        store(3'b010, 32'h8001_0004, 32'h1234_5678);
        @(negedge clk);
        chk("cfg_value", conv_cfg_o, 32'h1234_5678);
        chk("cfg_no_start", {31'b0, conv_start_o}, 32'h0);
        store(3'b000, 32'h8001_0000, 32'h0);
        @(negedge clk);
        idle();
        chk("start_pulse", {31'b0, conv_start_o}, 32'h1);
        chk("start_cfg", conv_cfg_o, 32'h1234_5678);
        @(negedge clk);
        chk("start_end", {31'b0, conv_start_o}, 32'h0);

        // Reset mid-transfer drops the byte
        tx_ready_i = 1'b0;
        store(3'b000, 32'h8000_0008, 32'h0000_0055);
        @(negedge clk);
        idle();
        chk("pre_rst_valid", {31'b0, tx_valid_o}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, tx_valid_o}, 32'h0);
        chk("async_data", {24'b0, tx_data_o}, 32'h0);
        chk("async_cycle", cycle_cnt_o, 32'h0);
        chk("async_cfg", conv_cfg_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready_i = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'b0, tx_valid_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
